// File: rtl/mips_shift_pkg.sv
// ---------------------------------------------------------------------------
// mips_shift_pkg
// Shared definitions for the sequential MIPS shift unit:
//   - datapath / shift-amount widths
//   - shift mode encodings (SRL, SLL, SRA, reserved)
//   - FSM state encoding for the controller
//   - helpers for locating set bits in the shift amount (used when
//     zero-weight stages are skipped)
// ---------------------------------------------------------------------------
package mips_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    // Stage index 0..SHAMT_W-1 fits in three bits.
    localparam int IDX_W   = 3;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SLL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Index of the most significant set bit; 0 when no bit is set, which
    // turns an all-zero amount into a single pass-through step at stage 0.
    function automatic logic [IDX_W-1:0] highest_set(input logic [SHAMT_W-1:0] bits);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (bits[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Bits of amt strictly below position k.
    function automatic logic [SHAMT_W-1:0] bits_below(input logic [SHAMT_W-1:0] amt,
                                                      input logic [IDX_W-1:0]   k);
        logic [SHAMT_W-1:0] mask;
        mask = (SHAMT_W'(1) << k) - SHAMT_W'(1);
        return amt & mask;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// One fixed-distance combinational shift stage with an enable bypass.
//   i_data  : value to shift
//   i_en    : 1 = shift by SI, 0 = pass i_data through unchanged
//   i_mode  : SRL / SLL / SRA (reserved code behaves as SRL here; the
//             controller forces the final result to zero for it)
//   o_data  : shifted (or bypassed) value
// ---------------------------------------------------------------------------
module shift_stage
#(
    parameter int DATA_W = 32,
    parameter int SI     = 1
)
(
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data
);
    import mips_shift_pkg::*;

    logic signed [DATA_W-1:0] w_signed_in;

    assign w_signed_in = $signed(i_data);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_mode)
                SH_SLL:  o_data = i_data << SI;
                // Arithmetic shift replicates bit DATA_W-1 of the running
                // value, which still carries the original sign.
                SH_SRA:  o_data = $unsigned(w_signed_in >>> SI);
                default: o_data = i_data >> SI;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Sequential SLL/SRL/SRA unit for the MIPS execute stage. The shift amount
// is applied as binary-weighted steps (16, 8, 4, 2, 1), one step per clock,
// each enabled by the matching shamt bit.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   request pulse, only sampled in IDLE
//   a       in   operand to shift
//   shamt   in   shift amount 0..31
//   mode    in   00 SRL, 01 SLL, 10 SRA, 11 reserved (result 0)
//   busy    out  high while an operation is in progress
//   done    out  one-cycle completion pulse
//   result  out  shifted value, held until the next completion or reset
//
// Parameters:
//   DATA_W     datapath width (only 32 supported)
//   SHAMT_W    shift-amount width (log2(DATA_W))
//   EARLY_EXIT 0 = visit every stage (fixed 5-cycle latency)
//              1 = visit only stages whose shamt bit is set
// ---------------------------------------------------------------------------
module shift_seq_ctrl
#(
    parameter int DATA_W     = 32,
    parameter int SHAMT_W    = 5,
    parameter int EARLY_EXIT = 0
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);
    import mips_shift_pkg::*;

    state_t             r_state;
    state_t             w_next_state;

    logic [DATA_W-1:0]  r_acc;
    logic [SHAMT_W-1:0] r_amt;
    logic [1:0]         r_md;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_result;

    logic [DATA_W-1:0]  w_stage [SHAMT_W];
    logic [DATA_W-1:0]  w_step;
    logic [IDX_W-1:0]   w_first_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_last;

    // Stage g shifts by 2^g; all stages see the same accumulator and the
    // one selected by the current index is written back.
    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        shift_stage #(
            .DATA_W (DATA_W),
            .SI     (1 << g)
        ) u_stage (
            .i_data (r_acc),
            .i_en   (r_amt[g]),
            .i_mode (r_md),
            .o_data (w_stage[g])
        );
    end

    assign w_step = w_stage[r_idx];

    // Stage sequencing: fixed countdown, or jump between set bits only.
    always_comb begin
        if (EARLY_EXIT != 0) begin
            w_first_idx = highest_set(shamt);
            w_last      = (bits_below(r_amt, r_idx) == '0);
            w_next_idx  = highest_set(bits_below(r_amt, r_idx));
        end else begin
            w_first_idx = IDX_W'(SHAMT_W - 1);
            w_last      = (r_idx == '0);
            w_next_idx  = r_idx - IDX_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next_state = ST_DONE;
            ST_DONE:              w_next_state = ST_IDLE;
            default:              w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == ST_SHIFT);
        done = (r_state == ST_DONE);
    end

    // Operand latch, accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_amt    <= '0;
            r_md     <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= a;
                        r_amt <= shamt;
                        r_md  <= mode;
                        r_idx <= w_first_idx;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_step;
                    if (w_last) begin
                        r_result <= (r_md == SH_RSV) ? '0 : w_step;
                    end else begin
                        r_idx <= w_next_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
